task_7_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single task-7 input FIFO loader between two byte-stream sources. Sits upstream of the input buffer. Grants one source at a time and forwards whole packets (tvalid/tready/tlast) without interleaving. Enforces a maximum packet length by forcing tlast and discarding the overrun. Counts completed packets per source.

---
 rtl/task_7_stream_arbiter.sv | 169 ++++++++++++++++
 tb/tb_task_7_stream_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_7_stream_arbiter.sv
// -----------------------------------------------------------------------------
// task_7_stream_arbiter
//
// Packet-level round-robin arbiter that lets two byte-stream sources share the
// single task-7 input FIFO loader. One source is granted at a time and whole
// packets are forwarded, so packets from the two sources are never interleaved.
// Packets longer than MAX_LEN are cut: beat MAX_LEN is marked tlast downstream
// and the rest of the source packet is consumed and discarded.
//
// Parameters:
//   MAX_LEN  maximum bytes forwarded per packet (>= 2)
//   CNT_W    width of the per-source completed-packet counters
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_s0_tvalid/tdata/tlast, o_s0_tready   source 0 stream
//   i_s1_tvalid/tdata/tlast, o_s1_tready   source 1 stream
//   o_m_tvalid/tdata/tlast, i_m_tready     stream to the input buffer
//   i_m_busy       input buffer busy; holds off new grants only
//   o_grant        one-hot current grant (bit0 = s0), 00 when idle
//   o_trunc        one-cycle pulse in the cycle after a forced-tlast beat
//   o_s0_pkt_cnt, o_s1_pkt_cnt   saturating completed-packet counters
// -----------------------------------------------------------------------------
module task_7_stream_arbiter #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s0_tvalid,
  input  logic [7:0]       i_s0_tdata,
  input  logic             i_s0_tlast,
  output logic             o_s0_tready,
  input  logic             i_s1_tvalid,
  input  logic [7:0]       i_s1_tdata,
  input  logic             i_s1_tlast,
  output logic             o_s1_tready,
  output logic             o_m_tvalid,
  output logic [7:0]       o_m_tdata,
  output logic             o_m_tlast,
  input  logic             i_m_tready,
  input  logic             i_m_busy,
  output logic [1:0]       o_grant,
  output logic             o_trunc,
  output logic [CNT_W-1:0] o_s0_pkt_cnt,
  output logic [CNT_W-1:0] o_s1_pkt_cnt
);

  localparam int BC_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t            state_reg;
  logic [1:0]        grant_reg;
  logic              ptr_reg;       // 0: s0 wins ties, 1: s1 wins ties
  logic [BC_W-1:0]   byte_cnt_reg;  // beats already forwarded in this packet
  logic              trunc_reg;

  logic              sel;
  logic              sel_tvalid;
  logic [7:0]        sel_tdata;
  logic              sel_tlast;
  logic              in_pass;
  logic              in_drop;
  logic              force_last;
  logic              beat;
  logic              src_ready;
  logic              pick_s1;
  logic [1:0]        req;
  logic [1:0]        pkt_done;

  // Source mux: the grant register selects which source feeds the output.
  assign sel        = grant_reg[1];
  assign sel_tvalid = sel ? i_s1_tvalid : i_s0_tvalid;
  assign sel_tdata  = sel ? i_s1_tdata  : i_s0_tdata;
  assign sel_tlast  = sel ? i_s1_tlast  : i_s0_tlast;

  assign in_pass    = (state_reg == PASS);
  assign in_drop    = (state_reg == DROP);

  // The beat currently offered is number byte_cnt+1; force tlast on beat MAX_LEN.
  assign force_last = (byte_cnt_reg == BC_W'(MAX_LEN - 1));

  assign o_m_tvalid = in_pass & sel_tvalid;
  assign o_m_tdata  = in_pass ? sel_tdata : 8'h00;
  assign o_m_tlast  = in_pass & (sel_tlast | force_last);
  assign beat       = o_m_tvalid & i_m_tready;

  // In DROP the granted source is drained unconditionally.
  assign src_ready   = in_pass ? i_m_tready : in_drop;
  assign o_s0_tready = grant_reg[0] & src_ready;
  assign o_s1_tready = grant_reg[1] & src_ready;

  assign o_grant = grant_reg;
  assign o_trunc = trunc_reg;

  // A packet is complete on its final downstream beat, forced or not.
  assign pkt_done = {2{beat & o_m_tlast}} & grant_reg;

  // Round-robin pick, only meaningful when at least one source requests.
  assign req     = {i_s1_tvalid, i_s0_tvalid};
  assign pick_s1 = ptr_reg ? req[1] : ~req[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'b00;
      ptr_reg      <= 1'b0;
      byte_cnt_reg <= '0;
      trunc_reg    <= 1'b0;
    end else begin
      trunc_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!i_m_busy && (|req)) begin
            grant_reg    <= pick_s1 ? 2'b10 : 2'b01;
            byte_cnt_reg <= '0;
            state_reg    <= PASS;
          end
        end
        PASS: begin
          if (beat) begin
            byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
            if (o_m_tlast) begin
              ptr_reg <= ~sel;
              if (sel_tlast) begin
                // Source tlast wins even when it lands exactly on beat MAX_LEN.
                state_reg <= IDLE;
                grant_reg <= 2'b00;
              end else begin
                state_reg <= DROP;
                trunc_reg <= 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (sel_tvalid && sel_tlast) begin
            state_reg <= IDLE;
            grant_reg <= 2'b00;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  // Per-source saturating packet counters.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_reg <= '0;
        end else if (pkt_done[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign o_s0_pkt_cnt = g_cnt[0].cnt_reg;
  assign o_s1_pkt_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_task_7_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_task_7_stream_arbiter
//
// Directed bench for task_7_stream_arbiter with MAX_LEN = 8. Sources are driven
// by a small packet task; a monitor records every downstream beat, the grant of
// every cycle and any o_trunc pulse. Inputs change on the falling edge and
// outputs are sampled shortly after it.
// -----------------------------------------------------------------------------
module tb_task_7_stream_arbiter;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0]       s0_data = 8'h00, s1_data = 8'h00;
  logic             s0_last = 1'b0, s1_last = 1'b0;
  logic             s0_ready, s1_ready;
  logic             m_valid, m_last;
  logic [7:0]       m_data;
  logic             m_tready = 1'b1;
  logic             m_busy = 1'b0;
  logic [1:0]       grant;
  logic             trunc;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  logic [1:0] q_grant[$];
  logic [1:0] gq[$];
  int         cyc = 0;
  int         trunc_n = 0;
  int         trunc_cyc = 0;
  int         last_cyc = 0;

  always #5 clk = ~clk;

  task_7_stream_arbiter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s0_tvalid(s0_valid), .i_s0_tdata(s0_data), .i_s0_tlast(s0_last), .o_s0_tready(s0_ready),
    .i_s1_tvalid(s1_valid), .i_s1_tdata(s1_data), .i_s1_tlast(s1_last), .o_s1_tready(s1_ready),
    .o_m_tvalid(m_valid), .o_m_tdata(m_data), .o_m_tlast(m_last), .i_m_tready(m_tready),
    .i_m_busy(m_busy), .o_grant(grant), .o_trunc(trunc),
    .o_s0_pkt_cnt(cnt0), .o_s1_pkt_cnt(cnt1)
  );

  // Monitor: one sample per cycle, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (m_valid && m_tready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_grant.push_back(grant);
      if (m_last) last_cyc = cyc;
    end
    if (trunc) begin
      trunc_n++;
      trunc_cyc = cyc;
    end
    gq.push_back(grant);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required orderly finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_grant.delete();
    gq.delete();
    trunc_n = 0;
  endtask

  task automatic drive_src(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 0) begin
      s0_valid = v; s0_data = d; s0_last = l;
    end else begin
      s1_valid = v; s1_data = d; s1_last = l;
    end
  endtask

  // Sends len bytes base, base+1, ... with tlast on the final byte.
  // w returns the number of cycles tvalid was held before the first acceptance.
  task automatic send_pkt(input int src, input int len, input logic [7:0] base, output int w);
    int  idx;
    int  guard;
    logic rdy;
    idx = 0; w = 0; guard = 0;
    while (idx < len) begin
      @(negedge clk);
      drive_src(src, 1'b1, base + 8'(idx), idx == len - 1);
      #1;
      rdy = (src == 0) ? s0_ready : s1_ready;
      @(posedge clk);
      if (rdy) idx++;
      else if (idx == 0) w++;
      guard++;
      if (guard > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout src=%0d: accepted %0d beats, required %0d", src, idx, len);
        break;
      end
    end
    @(negedge clk);
    drive_src(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 8'h00; s1_data = 8'h00;
    s0_last = 1'b0; s1_last = 1'b0; m_tready = 1'b1; m_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid got %b need 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_tlast got %b need 0", m_last); end
    n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_m_tdata got %h need 00", m_data); end
    n_cmp++; if ({s1_ready, s0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_treadys got %b need 00", {s1_ready, s0_ready}); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b need 00", grant); end
    n_cmp++; if (trunc !== 1'b0) begin n_err++; $display("FAIL reset_trunc got %b need 0", trunc); end
    n_cmp++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d need 0/0", cnt0, cnt1); end
  endtask

  task automatic test_lone_s0();
    int w;
    clear_mon();
    send_pkt(0, 4, 8'hA0, w);
    #1;
    n_cmp++; if (w != 1) begin n_err++; $display("FAIL lone_grant_latency got %0d need 1", w); end
    n_cmp++; if (q_data.size() != 4) begin n_err++; $display("FAIL lone_beats got %0d need 4", q_data.size()); end
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== 8'hA0 + 8'(k) || q_last[k] !== (k == 3) || q_grant[k] !== 2'b01) begin
        n_err++;
        $display("FAIL lone_beat%0d got d=%h l=%b g=%b need d=%h l=%b g=01", k, q_data[k], q_last[k], q_grant[k], 8'hA0 + 8'(k), k == 3);
      end
    end
    n_cmp++; if (cnt0 !== 16'd1) begin n_err++; $display("FAIL lone_cnt0 got %0d need 1", cnt0); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL lone_idle_grant got %b need 00", grant); end
  endtask

  task automatic test_round_robin();
    int w0, w1, w2, w3;
    int bad;
    logic [7:0] exp_d[12];
    logic [1:0] exp_g[12];
    do_reset();
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      exp_d[k]     = 8'hB0 + 8'(k); exp_g[k]     = 2'b01;
      exp_d[k + 3] = 8'hC0 + 8'(k); exp_g[k + 3] = 2'b10;
      exp_d[k + 6] = 8'hB6 + 8'(k); exp_g[k + 6] = 2'b01;
      exp_d[k + 9] = 8'hC6 + 8'(k); exp_g[k + 9] = 2'b10;
    end
    fork
      begin send_pkt(0, 3, 8'hB0, w0); send_pkt(0, 3, 8'hB6, w1); end
      begin send_pkt(1, 3, 8'hC0, w2); send_pkt(1, 3, 8'hC6, w3); end
    join
    #1;
    n_cmp++; if (q_data.size() != 12) begin n_err++; $display("FAIL rr_beats got %0d need 12", q_data.size()); end
    for (int k = 0; k < 12 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== exp_d[k] || q_grant[k] !== exp_g[k] || q_last[k] !== (k % 3 == 2)) begin
        n_err++;
        $display("FAIL rr_beat%0d got d=%h g=%b l=%b need d=%h g=%b l=%b", k, q_data[k], q_grant[k], q_last[k], exp_d[k], exp_g[k], k % 3 == 2);
      end
    end
    bad = 0;
    for (int k = 1; k < gq.size(); k++)
      if (gq[k - 1] != 2'b00 && gq[k] != 2'b00 && gq[k - 1] != gq[k]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rr_no_idle_between got %0d direct switches need 0", bad); end
    n_cmp++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin n_err++; $display("FAIL rr_counts got %0d/%0d need 2/2", cnt0, cnt1); end
  endtask

  task automatic test_backpressure();
    int w;
    int mir_n, mir_bad;
    logic done;
    do_reset();
    clear_mon();
    mir_n = 0; mir_bad = 0; done = 1'b0;
    fork
      begin send_pkt(1, 6, 8'hD0, w); done = 1'b1; end
      begin
        while (!done) begin
          @(negedge clk);
          m_tready = ~m_tready;
          #1;
          if (grant == 2'b10) begin
            mir_n++;
            if (s1_ready !== m_tready) mir_bad++;
          end
        end
      end
    join
    m_tready = 1'b1;
    #1;
    n_cmp++; if (mir_bad != 0 || mir_n == 0) begin n_err++; $display("FAIL bp_ready_mirror got %0d bad of %0d cycles need 0 bad", mir_bad, mir_n); end
    n_cmp++; if (q_data.size() != 6) begin n_err++; $display("FAIL bp_beats got %0d need 6", q_data.size()); end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== 8'hD0 + 8'(k) || q_last[k] !== (k == 5) || q_grant[k] !== 2'b10) begin
        n_err++;
        $display("FAIL bp_beat%0d got d=%h l=%b g=%b need d=%h l=%b g=10", k, q_data[k], q_last[k], q_grant[k], 8'hD0 + 8'(k), k == 5);
      end
    end
    n_cmp++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL bp_cnt1 got %0d need 1", cnt1); end
  endtask

  task automatic test_trunc();
    int w;
    do_reset();
    clear_mon();
    send_pkt(1, 12, 8'hE0, w);
    #1;
    n_cmp++; if (q_data.size() != 8) begin n_err++; $display("FAIL trunc_beats got %0d need 8", q_data.size()); end
    for (int k = 0; k < 8 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== 8'hE0 + 8'(k) || q_last[k] !== (k == 7)) begin
        n_err++;
        $display("FAIL trunc_beat%0d got d=%h l=%b need d=%h l=%b", k, q_data[k], q_last[k], 8'hE0 + 8'(k), k == 7);
      end
    end
    n_cmp++; if (trunc_n != 1) begin n_err++; $display("FAIL trunc_pulses got %0d need 1", trunc_n); end
    n_cmp++; if (trunc_cyc != last_cyc + 1) begin n_err++; $display("FAIL trunc_timing got cycle %0d need %0d", trunc_cyc, last_cyc + 1); end
    n_cmp++; if (cnt1 !== 16'd1 || grant !== 2'b00) begin n_err++; $display("FAIL trunc_after got cnt1=%0d g=%b need 1/00", cnt1, grant); end
    clear_mon();
    send_pkt(1, 8, 8'hF0, w);
    #1;
    n_cmp++; if (q_data.size() != 8) begin n_err++; $display("FAIL exact_beats got %0d need 8", q_data.size()); end
    for (int k = 0; k < 8 && k < q_data.size(); k++) begin
      n_cmp++;
      if (q_data[k] !== 8'hF0 + 8'(k) || q_last[k] !== (k == 7)) begin
        n_err++;
        $display("FAIL exact_beat%0d got d=%h l=%b need d=%h l=%b", k, q_data[k], q_last[k], 8'hF0 + 8'(k), k == 7);
      end
    end
    n_cmp++; if (trunc_n != 0) begin n_err++; $display("FAIL exact_no_trunc got %0d pulses need 0", trunc_n); end
    n_cmp++; if (cnt1 !== 16'd2) begin n_err++; $display("FAIL exact_cnt1 got %0d need 2", cnt1); end
  endtask

  task automatic test_busy();
    int w;
    int held;
    do_reset();
    clear_mon();
    m_busy = 1'b1;
    held = 0;
    fork
      send_pkt(0, 4, 8'h40, w);
      begin
        repeat (10) begin
          @(negedge clk);
          #1;
          if (grant == 2'b00) held++;
        end
        @(negedge clk);
        m_busy = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL busy_release_grant got %b need 01", grant); end
        m_busy = 1'b1;
      end
    join
    #1;
    n_cmp++; if (held != 10) begin n_err++; $display("FAIL busy_hold got %0d idle cycles need 10", held); end
    n_cmp++; if (w != 11) begin n_err++; $display("FAIL busy_wait got %0d need 11", w); end
    n_cmp++; if (q_data.size() != 4 || cnt0 !== 16'd1) begin n_err++; $display("FAIL busy_complete got %0d beats cnt0=%0d need 4/1", q_data.size(), cnt0); end
    m_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    send_pkt(0, 2, 8'h10, w);
    #1;
    n_cmp++; if (cnt0 !== 16'd1) begin n_err++; $display("FAIL mid_pre_cnt0 got %0d need 1", cnt0); end
    @(negedge clk); drive_src(1, 1'b1, 8'h60, 1'b0);
    @(negedge clk);
    @(negedge clk); drive_src(1, 1'b1, 8'h61, 1'b0);
    @(negedge clk); drive_src(1, 1'b1, 8'h62, 1'b0); rst = 1'b1;
    #1;
    n_cmp++; if (!(m_valid === 1'b1 && m_data === 8'h62)) begin n_err++; $display("FAIL mid_beat3 got v=%b d=%h need 1/62", m_valid, m_data); end
    @(negedge clk);
    rst = 1'b0;
    drive_src(1, 1'b1, 8'h63, 1'b0);
    drive_src(0, 1'b1, 8'h70, 1'b0);
    #1;
    n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_m got v=%b l=%b d=%h need 0/0/00", m_valid, m_last, m_data); end
    n_cmp++; if (grant !== 2'b00 || {s1_ready, s0_ready} !== 2'b00 || trunc !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl got g=%b rdy=%b t=%b need 00/00/0", grant, {s1_ready, s0_ready}, trunc); end
    n_cmp++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin n_err++; $display("FAIL mid_rst_counts got %0d/%0d need 0/0", cnt0, cnt1); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL mid_first_grant got %b need 01", grant); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_lone_s0();
    test_round_robin();
    test_backpressure();
    test_trunc();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
